pipe_stage_skid: RTL

//  Parametrised inter-stage pipeline register for IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.

---
 rtl/pipe_stage_skid_if.sv | 52 +++++
 rtl/pipe_stage_skid.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_if
// Description : Handshake bundle for one pipe_stage_skid boundary.
//               Upstream side : in_valid / in_ready / in_data / in_ctrl /
//                               in_instr, plus the bubble and flush controls.
//               Downstream    : out_valid / out_ready / out_data / out_ctrl /
//                               out_instr, plus the occupancy status.
//               modport master : the environment (drives inputs, observes
//                                outputs).
//               modport slave  : the pipeline stage itself.
// Revision    : 1.0  initial release
// ============================================================================
interface pipe_stage_skid_if #(
  parameter int DATA_W  = 16,
  parameter int CTRL_W  = 16,
  parameter int INSTR_W = 16
) ();

  // upstream handshake
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [CTRL_W-1:0]  in_ctrl;
  logic [INSTR_W-1:0] in_instr;

  // stage controls
  logic               bubble;
  logic               flush;

  // downstream handshake
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [INSTR_W-1:0] out_instr;

  // status
  logic [1:0]         occupancy;

  modport master (
    output in_valid, in_data, in_ctrl, in_instr, bubble, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_instr, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, in_instr, bubble, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_instr, occupancy
  );

endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB)
//               with a one-entry skid buffer. in_ready depends on registered
//               state only, so out_ready never has a combinational path to
//               in_ready. Supports bubble injection (NOP instruction, masked
//               control bits cleared) and flush (stage emptied, offered
//               entry dropped).
// Ports       : clk        clock, rising edge
//               rst        asynchronous active-high reset
//               bus.slave  handshake bundle (see pipe_stage_skid_if)
//                 in_valid/in_ready/in_data/in_ctrl/in_instr  upstream
//                 bubble  accepted entry becomes a NOP bubble
//                 flush   discard held entries and any offered entry
//                 out_valid/out_ready/out_data/out_ctrl/out_instr downstream
//                 occupancy  held entries 0..2
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int                  DATA_W         = 16,
  parameter int                  CTRL_W         = 16,
  parameter int                  INSTR_W        = 16,
  parameter logic [INSTR_W-1:0]  NOP_INSTR      = INSTR_W'(16'h0800),
  parameter logic [CTRL_W-1:0]   CTRL_KILL_MASK = {CTRL_W{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  pipe_stage_skid_if.slave    bus
);

  // --------------------------------------------------------------------------
  // State encoding doubles as the occupancy count.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t             r_state;

  // head = entry presented downstream; skid = second entry caught while
  // the head was stalled
  logic [DATA_W-1:0]  r_head_data;
  logic [CTRL_W-1:0]  r_head_ctrl;
  logic [INSTR_W-1:0] r_head_instr;
  logic [DATA_W-1:0]  r_skid_data;
  logic [CTRL_W-1:0]  r_skid_ctrl;
  logic [INSTR_W-1:0] r_skid_instr;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_in_fire;
  logic               w_out_fire;

  logic [DATA_W-1:0]  w_entry_data;
  logic [CTRL_W-1:0]  w_entry_ctrl;
  logic [INSTR_W-1:0] w_entry_instr;

  // --------------------------------------------------------------------------
  // Handshake decode. Both ready and valid come straight from r_state.
  // --------------------------------------------------------------------------
  assign w_in_ready  = (r_state != SKID);
  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  // --------------------------------------------------------------------------
  // Entry formation: a bubble keeps its data, clears the kill-masked control
  // bits and substitutes the NOP instruction, but stays a valid entry.
  // --------------------------------------------------------------------------
  assign w_entry_data  = bus.in_data;
  assign w_entry_ctrl  = bus.bubble ? (bus.in_ctrl & ~CTRL_KILL_MASK) : bus.in_ctrl;
  assign w_entry_instr = bus.bubble ? NOP_INSTR : bus.in_instr;

  // --------------------------------------------------------------------------
  // Stage FSM and storage.
  // Flush has highest priority; an out_fire in the flush cycle has already
  // been consumed downstream, so nothing needs to be retained.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= EMPTY;
      r_head_data  <= '0;
      r_head_ctrl  <= '0;
      r_head_instr <= NOP_INSTR;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
      r_skid_instr <= NOP_INSTR;
    end else if (bus.flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_state      <= FULL;
            r_head_data  <= w_entry_data;
            r_head_ctrl  <= w_entry_ctrl;
            r_head_instr <= w_entry_instr;
          end
        end

        FULL: begin
          if (w_in_fire && w_out_fire) begin
            // head leaves and is replaced in the same cycle
            r_head_data  <= w_entry_data;
            r_head_ctrl  <= w_entry_ctrl;
            r_head_instr <= w_entry_instr;
          end else if (w_out_fire) begin
            r_state <= EMPTY;
          end else if (w_in_fire) begin
            // downstream stalled: park the newcomer behind the head
            r_state      <= SKID;
            r_skid_data  <= w_entry_data;
            r_skid_ctrl  <= w_entry_ctrl;
            r_skid_instr <= w_entry_instr;
          end
        end

        SKID: begin
          // in_ready is low here, so only draining is possible
          if (w_out_fire) begin
            r_state      <= FULL;
            r_head_data  <= r_skid_data;
            r_head_ctrl  <= r_skid_ctrl;
            r_head_instr <= r_skid_instr;
          end
        end

        default: begin
          r_state <= EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Control and instruction are masked to their idle values when
  // nothing is held, so a stale head never leaks RegWrite-style bits.
  // --------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_head_data;
  assign bus.out_ctrl  = w_out_valid ? r_head_ctrl  : '0;
  assign bus.out_instr = w_out_valid ? r_head_instr : NOP_INSTR;
  assign bus.occupancy = r_state;

endmodule
`default_nettype wire
